// File: rtl/r_inv_hold_sched_pkg.sv
// Shared FSM encoding and default frame-timing constants for the
// inverse-result hold scheduler.
package r_inv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_CAP = 2'd1,
      ST_HOLD     = 2'd2,
      ST_BLANK    = 2'd3
   } state_e;

   localparam int DEF_DATA_W    = 32;
   localparam int DEF_N_ELEM    = 4;
   localparam int DEF_PERIOD    = 1026;
   localparam int DEF_CAP_START = 100;
   localparam int DEF_CAP_END   = 100;
   localparam int DEF_REL_AT    = 1020;
   localparam int DEF_KEEP_LAST = 0;

endpackage

// File: rtl/r_inv_hold_sched_if.sv
// Control, input-result and held-output signals of the hold scheduler,
// grouped so the producer side and the scheduler share one bundle.
interface r_inv_hold_sched_if
   import r_inv_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int N_ELEM = DEF_N_ELEM
);
   logic                       I_en;
   logic                       I_sync;
   logic                       I_in_valid;
   logic [N_ELEM*DATA_W-1:0]   I_elem;
   logic [N_ELEM*DATA_W-1:0]   O_elem;
   logic                       O_out_valid;
   logic                       O_frame_start;
   logic                       O_miss;
   logic [7:0]                 O_miss_cnt;

   modport master (
      output I_en, I_sync, I_in_valid, I_elem,
      input  O_elem, O_out_valid, O_frame_start, O_miss, O_miss_cnt
   );

   modport slave (
      input  I_en, I_sync, I_in_valid, I_elem,
      output O_elem, O_out_valid, O_frame_start, O_miss, O_miss_cnt
   );
endinterface

// File: rtl/r_inv_hold_sched_frame_cnt.sv
// Frame position counter: runs 0..PERIOD-1 while enabled, held at 0 when
// disabled, and restarted at 0 by a sync pulse.
module r_inv_frame_cnt #(
   parameter int PERIOD = 16,
   parameter int CNT_W  = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_sync,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_wrap
);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_last;

   assign w_last = (r_cnt == C_LAST);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (!i_en || i_sync || w_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt  = r_cnt;
   assign o_wrap = w_last;
endmodule

// File: rtl/r_inv_hold_sched.sv
// Captures one inverse result per frame inside a count window, holds it
// until the release count, and flags frames whose window closed empty.
module r_inv_hold_sched
   import r_inv_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int N_ELEM    = DEF_N_ELEM,
   parameter int PERIOD    = DEF_PERIOD,
   parameter int CAP_START = DEF_CAP_START,
   parameter int CAP_END   = DEF_CAP_END,
   parameter int REL_AT    = DEF_REL_AT,
   parameter int KEEP_LAST = DEF_KEEP_LAST
) (
   input  logic              I_sys_clk,
   input  logic              I_sys_rst,
   r_inv_hold_sched_if.slave bus
);
   localparam int CNT_W = $clog2(PERIOD);
   localparam logic [CNT_W-1:0] C_CAP_START = CNT_W'(CAP_START);
   localparam logic [CNT_W-1:0] C_CAP_END   = CNT_W'(CAP_END);
   localparam logic [CNT_W-1:0] C_REL_AT    = CNT_W'(REL_AT);

   if (!(CAP_START <= CAP_END && CAP_END < REL_AT && REL_AT <= PERIOD - 1 && PERIOD >= 4))
   begin : g_param_check
      $error("r_inv_hold_sched: frame timing parameters out of order");
   end

   logic [CNT_W-1:0] w_cnt;
   logic             w_wrap;
   state_e           r_state;
   state_e           w_state_next;
   logic             w_in_win;
   logic             w_capture;
   logic             w_miss;
   logic             r_valid;
   logic             r_miss;
   logic [7:0]       r_miss_cnt;

   r_inv_frame_cnt #(
      .PERIOD (PERIOD),
      .CNT_W  (CNT_W)
   ) u_frame_cnt (
      .i_clk  (I_sys_clk),
      .i_rst  (I_sys_rst),
      .i_en   (bus.I_en),
      .i_sync (bus.I_sync),
      .o_cnt  (w_cnt),
      .o_wrap (w_wrap)
   );

   assign w_in_win = (w_cnt >= C_CAP_START) && (w_cnt <= C_CAP_END);

   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      w_miss       = 1'b0;
      if (!bus.I_en) begin
         w_state_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: w_state_next = ST_WAIT_CAP;
            ST_WAIT_CAP: begin
               // a sync in the same cycle as a valid result aborts the capture
               if (bus.I_sync) begin
                  w_state_next = ST_WAIT_CAP;
               end else if (w_in_win && bus.I_in_valid) begin
                  w_capture    = 1'b1;
                  w_state_next = ST_HOLD;
               end else if (w_cnt == C_CAP_END) begin
                  w_miss       = 1'b1;
                  w_state_next = ST_BLANK;
               end
            end
            ST_HOLD: begin
               if (bus.I_sync) begin
                  w_state_next = ST_WAIT_CAP;
               end else if (w_cnt == C_REL_AT) begin
                  // release on the last count goes straight into the next frame
                  w_state_next = w_wrap ? ST_WAIT_CAP : ST_BLANK;
               end
            end
            ST_BLANK: begin
               if (bus.I_sync || w_wrap) w_state_next = ST_WAIT_CAP;
            end
            default: w_state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge I_sys_clk or posedge I_sys_rst) begin
      if (I_sys_rst) begin
         r_state    <= ST_IDLE;
         r_valid    <= 1'b0;
         r_miss     <= 1'b0;
         r_miss_cnt <= '0;
      end else begin
         r_state <= w_state_next;
         r_valid <= (w_state_next == ST_HOLD);
         r_miss  <= w_miss;
         if (w_miss && (r_miss_cnt != 8'hFF)) r_miss_cnt <= r_miss_cnt + 8'd1;
      end
   end

   // without KEEP_LAST the data register is zero in every state except HOLD
   for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_elem
      logic [DATA_W-1:0] r_elem;
      always_ff @(posedge I_sys_clk or posedge I_sys_rst) begin
         if (I_sys_rst) begin
            r_elem <= '0;
         end else if (w_capture) begin
            r_elem <= bus.I_elem[gi*DATA_W +: DATA_W];
         end else if ((KEEP_LAST == 0) && (w_state_next != ST_HOLD)) begin
            r_elem <= '0;
         end
      end
      assign bus.O_elem[gi*DATA_W +: DATA_W] = r_elem;
   end

   assign bus.O_out_valid   = r_valid;
   assign bus.O_miss        = r_miss;
   assign bus.O_miss_cnt    = r_miss_cnt;
   assign bus.O_frame_start = bus.I_en && (w_cnt == '0) && !I_sys_rst;
endmodule

// File: doc/r_inv_hold_sched.md
R_INV_HOLD_SCHED -- requirements
Module: r_inv_hold_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 32, bit width of one matrix element.
REQ-002 SHALL have parameter N_ELEM, default 4, number of elements per result (4 = 2x2 inverse).
REQ-003 SHALL have parameter PERIOD, default 1026, frame length in clocks; counter runs 0..PERIOD-1.
REQ-004 SHALL have parameter CAP_START, default 100, first frame count at which capture is allowed.
REQ-005 SHALL have parameter CAP_END, default 100, last frame count at which capture is allowed.
REQ-006 SHALL have parameter REL_AT, default 1020, frame count at which the held result is released.
REQ-007 SHALL have parameter KEEP_LAST, default 0; 0 = zero data outside hold, 1 = retain last captured data.
REQ-008 I_sys_clk  in  1  sole clock, rising edge.
REQ-009 I_sys_rst  in  1  reset, asynchronous, active-high.
REQ-010 I_en  in  1  frame counter run enable.
REQ-011 I_sync  in  1  frame resync pulse.
REQ-012 I_in_valid  in  1  input result valid.
REQ-013 I_elem  in  N_ELEM*DATA_W  flattened input elements, element k at bits [k*DATA_W +: DATA_W].
REQ-014 O_elem  out  N_ELEM*DATA_W  held output elements, same packing.
REQ-015 O_out_valid  out  1  O_elem holds a result captured in the current frame.
REQ-016 O_frame_start  out  1  one-cycle pulse when counter equals 0.
REQ-017 O_miss  out  1  one-cycle pulse when capture window closes without a capture.
REQ-018 O_miss_cnt  out  8  saturating count of missed frames.

Function
REQ-019 Counter SHALL increment by 1 per clock while I_en=1, wrap PERIOD-1 -> 0, and be forced to 0 while I_en=0.
REQ-020 I_sync=1 SHALL load counter with 0 next cycle, taking priority over increment and wrap.
REQ-021 FSM states SHALL be IDLE, WAIT_CAP, HOLD, BLANK.
REQ-022 IDLE -> WAIT_CAP when I_en=1; any state -> IDLE when I_en=0.
REQ-023 WAIT_CAP: first cycle with count in [CAP_START, CAP_END] and I_in_valid=1 SHALL register I_elem; O_elem and O_out_valid=1 update the following cycle (latency 1); state -> HOLD.
REQ-024 WAIT_CAP: if count == CAP_END and I_in_valid=0, O_miss SHALL pulse next cycle, O_miss_cnt increments (saturate at 255), state -> BLANK.
REQ-025 Capture SHALL occur at most once per frame; I_in_valid outside the window or in HOLD/BLANK SHALL be ignored.
REQ-026 HOLD: O_elem SHALL stay constant; at count == REL_AT, O_out_valid -> 0 next cycle, state -> BLANK.
REQ-027 Entering BLANK or IDLE, O_elem SHALL become all-zero when KEEP_LAST=0 and be unchanged when KEEP_LAST=1.
REQ-028 BLANK -> WAIT_CAP when count wraps to 0 (or on I_sync).
REQ-029 I_sync in WAIT_CAP/HOLD SHALL abort the frame: O_out_valid -> 0, data per REQ-027, no O_miss, state -> WAIT_CAP.
REQ-030 I_sync and capture in the same cycle: I_sync SHALL win, no capture.
REQ-031 O_frame_start SHALL be 1 exactly in cycles where count == 0 and I_en=1.
REQ-032 Elaboration SHALL fail unless CAP_START <= CAP_END < REL_AT <= PERIOD-1 and PERIOD >= 4.

Reset
REQ-033 On I_sys_rst=1, asynchronously: counter 0, state IDLE, O_elem 0, O_out_valid 0, O_frame_start 0, O_miss 0, O_miss_cnt 0.
REQ-034 Reset asserted mid-HOLD SHALL clear O_elem regardless of KEEP_LAST.

Structure
REQ-035 Package r_inv_pkg SHALL hold the FSM state encoding and default parameter constants.
REQ-036 Frame counter with sync/wrap SHALL be a sub-module r_inv_frame_cnt; FSM and data registers in top level.

Verification (DATA_W=32, N_ELEM=4, PERIOD=16, CAP_START=4, CAP_END=6, REL_AT=12)
REQ-037 Valid at count 5 with elems {1,2,3,4} -> O_elem={1,2,3,4}, O_out_valid=1 at count 6 through count 12, zero at count 13 (KEEP_LAST=0).
REQ-038 No valid in counts 4..6 -> O_miss pulse at count 7, O_miss_cnt=1, O_elem stays 0; 300 such frames -> O_miss_cnt=255.
REQ-039 KEEP_LAST=1, frame 1 captures 0xA5, frame 2 misses -> O_elem=0xA5 all elements through frame 2, O_out_valid=0 from count 13 of frame 1.
REQ-040 I_sync at count 9 during HOLD -> O_out_valid=0 next cycle, counter=0, next frame captures normally.
REQ-041 I_sys_rst asserted at count 8 in HOLD -> all outputs 0 immediately; after release, I_en=1 -> O_frame_start pulse first cycle.
REQ-042 Valid at counts 4 and 5 with different data -> only count-4 data held.
